// File: rtl/patching_pkg.sv
// Shared types and helpers for the activation-patching pipeline.
package patching_pkg;

  localparam int N_DEF     = 16;
  localparam int DEPTH_DEF = 64;

  // Index width for a cache of the given depth; at least one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

  // Triple handed to the patching stage: p=1 selects a_cache over a_org.
  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [N_DEF-1:0]     a_org;
    logic [N_DEF-1:0]     a_cache;
    logic                 p;
  } patch_triple_t;

endpackage

// File: rtl/comparador_umbral.sv
// Similarity check: |a - b| <= UMBRAL on signed activations, no wrap.
// Latency: combinational.
// Backpressure: none.
module comparador_umbral #(
  parameter int N      = 16,
  parameter int UMBRAL = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         hit_umbral
);

  localparam logic [N:0] UMB = (N+1)'(UMBRAL);

  logic signed [N:0] diff;
  logic        [N:0] absdiff;

  // One extra bit keeps the full signed range of a-b, so negation cannot overflow.
  assign diff       = $signed({a[N-1], a}) - $signed({b[N-1], b});
  assign absdiff    = diff[N] ? $unsigned(-diff) : $unsigned(diff);
  assign hit_umbral = (absdiff <= UMB);

endmodule

// File: rtl/cache_patching.sv
// Per-index activation cache producing the (a_org, a_cache, p) patching triple.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops while the output register is full and not draining, or on flush.
module cache_patching
  import patching_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = idx_width(DEPTH),
  parameter int UMBRAL = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [N-1:0]     in_act,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     a_org,
  output logic [N-1:0]     a_cache,
  output logic             p,
  output logic [CNT_W-1:0] cnt_patch
);

  // Same layout as patch_triple_t, sized by this instance's parameters.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     a_org;
    logic [N-1:0]     a_cache;
    logic             p;
  } triple_t;

  triple_t          out_q;
  triple_t          out_d;
  logic             out_vld_q;
  logic [DEPTH-1:0] entry_vld_q;
  logic [N-1:0]     cache_mem [DEPTH];
  logic [N-1:0]     cache_rd_dat;
  logic             entry_vld;
  logic             thr_hit;
  logic             hit;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;

  assign cache_rd_dat = cache_mem[in_idx];
  assign entry_vld    = entry_vld_q[in_idx];

  comparador_umbral #(
    .N      (N),
    .UMBRAL (UMBRAL)
  ) u_cmp (
    .a          (in_act),
    .b          (cache_rd_dat),
    .hit_umbral (thr_hit)
  );

  assign hit      = entry_vld && thr_hit;
  assign in_ready = !flush && (!out_vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d         = '0;
    out_d.idx     = in_idx;
    out_d.a_org   = in_act;
    out_d.a_cache = entry_vld ? cache_rd_dat : '0;
    out_d.p       = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      entry_vld_q <= '0;
      cnt_q       <= '0;
    end else begin
      // flush and accept are exclusive because flush forces in_ready low.
      if (flush)
        entry_vld_q <= '0;
      else if (accept && !hit)
        entry_vld_q[in_idx] <= 1'b1;

      if (accept) begin
        out_vld_q <= 1'b1;
        out_q     <= out_d;
      end else if (out_ready) begin
        out_vld_q <= 1'b0;
      end

      if (accept && hit && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Only misses refresh the reference, so hits never drift it.
  always_ff @(posedge clk) begin
    if (accept && !hit)
      cache_mem[in_idx] <= in_act;
  end

  assign out_valid = out_vld_q;
  assign out_idx   = out_q.idx;
  assign a_org     = out_q.a_org;
  assign a_cache   = out_q.a_cache;
  assign p         = out_q.p;
  assign cnt_patch = cnt_q;

endmodule

// File: tb/tb_cache_patching.sv
// Bench for cache_patching: vector tables plus hand sequences, scoreboarded outputs.
module tb_cache_patching;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_idx = '0;
  logic [15:0] in_act = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_idx;
  logic [15:0] a_org;
  logic [15:0] a_cache;
  logic        p;
  logic [3:0]  cnt_patch;

  cache_patching #(
    .N      (16),
    .DEPTH  (64),
    .UMBRAL (4),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_act    (in_act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .a_org     (a_org),
    .a_cache   (a_cache),
    .p         (p),
    .cnt_patch (cnt_patch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] act;
    logic        exp_p;
    logic [15:0] exp_cache;
    logic [3:0]  exp_cnt;
  } vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] a_org;
    logic [15:0] a_cache;
    logic        p;
    logic [3:0]  cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic [5:0] idx, input logic [15:0] act, input logic ep,
                          input logic [15:0] ec, input logic [3:0] ecnt);
    exp_t e;
    e.idx = idx; e.a_org = act; e.a_cache = ec; e.p = ep; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  task automatic add(input int idx, input int act, input bit ep, input int ec, input int ecnt);
    vec_t v;
    v.idx = 6'(idx); v.act = 16'(act); v.exp_p = ep; v.exp_cache = 16'(ec); v.exp_cnt = 4'(ecnt);
    tbl.push_back(v);
  endtask

  // Present one input, wait (bounded) for acceptance, record what must come out.
  task automatic send(input logic [5:0] idx, input logic [15:0] act, input logic ep,
                      input logic [15:0] ec, input logic [3:0] ecnt);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_idx = idx; in_act = act;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else push_exp(idx, act, ep, ec, ecnt);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_table();
    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i].idx, tbl[i].act, tbl[i].exp_p, tbl[i].exp_cache, tbl[i].exp_cnt);
    tbl.delete();
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk); #3; w++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Output monitor: a triple is consumed at the edge following a negedge with valid&ready.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_idx",   32'(out_idx),   32'(mon_e.idx));
          chk("a_org",     32'(a_org),     32'(mon_e.a_org));
          chk("a_cache",   32'(a_cache),   32'(mon_e.a_cache));
          chk("p",         32'(p),         32'(mon_e.p));
          chk("cnt_patch", 32'(cnt_patch), 32'(mon_e.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_a_org",     32'(a_org),     32'd0);
    chk("rst_a_cache",   32'(a_cache),   32'd0);
    chk("rst_p",         32'(p),         32'd0);
    chk("rst_cnt",       32'(cnt_patch), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Fill/hit, miss refresh, signed range and threshold boundary
    add(3, 100,    0, 0,      0);
    add(3, 102,    1, 100,    1);
    add(3, 96,     1, 100,    2);  // only hits if the reference stayed at 100
    add(3, 110,    0, 100,    2);
    add(3, 107,    1, 110,    3);
    add(3, 104,    0, 110,    3);
    add(7, 'hFFFE, 0, 0,      3);
    add(7, 1,      1, 'hFFFE, 4);
    add(8, 'h7FFF, 0, 0,      4);
    add(8, 'h8000, 0, 'h7FFF, 4);
    add(8, 'h8004, 1, 'h8000, 5);
    add(8, 'h8005, 0, 'h8000, 5);
    add(9, 100,    0, 0,      5);
    apply_table();
    drain();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("hold_a_org",     32'(a_org),     32'd100);
    chk("hold_out_idx",   32'(out_idx),   32'd9);

    // Backpressure: one accepted, second held three cycles, then accepted on release
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 6'd3; in_act = 16'd104;
    #1;
    chk("bp_first_ready", 32'(in_ready), 32'd1);
    push_exp(6'd3, 16'd104, 1'b1, 16'd104, 4'd6);
    @(negedge clk);
    in_act = 16'd200;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_a_org",    32'(a_org),     32'd104);
      chk("bp_a_cache",  32'(a_cache),   32'd104);
      chk("bp_p",        32'(p),         32'd1);
      chk("bp_cnt",      32'(cnt_patch), 32'd6);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    push_exp(6'd3, 16'd200, 1'b0, 16'd104, 4'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Flush blocks acceptance and invalidates every entry
    send(6'd5, 16'd50, 1'b0, 16'd0, 4'd6);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_idx = 6'd5; in_act = 16'd50;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    send(6'd5, 16'd50,  1'b0, 16'd0, 4'd6);
    send(6'd3, 16'd200, 1'b0, 16'd0, 4'd6);
    drain();

    // Counter saturation at 15, then reset mid-stream
    do_reset();
    add(0, 10, 0, 0, 0);
    for (int i = 1; i <= 20; i++) add(0, 10, 1, 10, (i < 15) ? i : 15);
    apply_table();
    drain();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 6'd0; in_act = 16'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sat_pending_valid", 32'(out_valid), 32'd1);
    chk("sat_pending_p",     32'(p),         32'd1);
    chk("sat_cnt_held",      32'(cnt_patch), 32'd15);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt",       32'(cnt_patch), 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    send(6'd0, 16'd10, 1'b0, 16'd0, 4'd0);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_patching.md
Name: cache_patching

Overview:
- Upstream stage of the activation-patching mux: it produces the (a_org, a_cache, p) triple that the patching stage consumes.
- Per neuron index it keeps the last non-patched activation in a register-array cache.
- On each accepted activation it compares the new value with the cached one. If |difference| <= UMBRAL it asserts p so downstream reuses the cached value; otherwise it refreshes the cache.
- Streams through a valid/ready interface with one output register stage.

Parameters:
- N, 16, activation width (signed two's complement).
- DEPTH, 64, number of cache entries (neuron indices); power of two.
- IDX_W, $clog2(DEPTH), index width.
- UMBRAL, 4, unsigned similarity threshold; 0 = exact match only.
- CNT_W, 16, width of the saturating patch counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  one-cycle pulse; invalidates all cache entries.
- in_valid  in  1  input activation valid.
- in_ready  out  1  block can accept the input this cycle.
- in_idx  in  IDX_W  neuron index of the input activation.
- in_act  in  N  input activation.
- out_valid  out  1  output triple valid.
- out_ready  in  1  downstream accepts the output.
- out_idx  out  IDX_W  index of the output triple.
- a_org  out  N  original activation (registered in_act).
- a_cache  out  N  cached activation at the moment of lookup.
- p  out  1  patch bit: 1 = downstream selects a_cache.
- cnt_patch  out  CNT_W  number of patched outputs, saturating.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_idx=0, a_org=0, a_cache=0, p=0, cnt_patch=0.
  - All DEPTH valid bits = 0.
  - Cache data array is not reset; don't-care while its valid bit is 0.
- in_ready = !flush && (!out_valid || out_ready). Combinational, so the output register refills in the same cycle it drains.
- Accept = in_valid && in_ready. Latency is 1 cycle: the triple appears on the outputs the cycle after accept.
- Lookup is a combinational read of entry in_idx.
- Difference: diff = sext(in_act) - sext(cache[in_idx]), computed in N+1 bits (no overflow wrap). absdiff is N+1 bits unsigned.
- Hit = valid[in_idx] && absdiff <= UMBRAL.
- On accept with hit:
  - p<=1, a_cache<=cache[in_idx].
  - Cache is unchanged; the reference value does not drift.
  - cnt_patch increments and saturates at all-ones.
- On accept with miss:
  - p<=0.
  - a_cache<=cache[in_idx] if valid, else 0.
  - cache[in_idx]<=in_act, valid[in_idx]<=1.
- On every accept: a_org<=in_act, out_idx<=in_idx, out_valid<=1.
- out_valid && !out_ready: all outputs hold stable; in_ready=0; cache untouched.
- out_valid && out_ready with no accept: out_valid<=0; data outputs hold their last values.
- Back-to-back same index: the write from accept k is visible to the lookup of accept k+1 (write at edge, combinational read after).
- flush:
  - Clears all valid bits at the next edge.
  - Blocks acceptance that cycle; flush wins over in_valid.
  - Does not disturb the pending output register or cnt_patch.
- rst mid-stream: any pending output is dropped (out_valid=0) and all entries are invalidated.
- cnt_patch is cleared only by rst.

Decomposition:
- Package patching_pkg:
  - Default N.
  - Function to derive IDX_W.
  - Typedef for the output triple {idx, a_org, a_cache, p}; shared with the patching stage.
- Sub-module comparador_umbral (N, UMBRAL): combinational sign-extended subtract, absolute value, <= compare, output hit_umbral.
- The remaining RTL in cache_patching covers valid bits, cache array, output register, handshake and counter.

Test Plan:
1. Cache fill and hit (UMBRAL=4). After rst: idx=3, act=100 -> p=0, a_cache=0, a_org=100. Then idx=3, act=102 -> p=1, a_cache=100, cnt_patch=1; cache[3] stays 100.
2. Miss refresh. cache[3]=100; act=110 -> p=0, a_cache=100, cache[3]<=110. Then act=107 -> p=1, a_cache=110. Then act=104 (diff 6) -> p=0.
3. Signed, no wrap. cache[7]=-2 (0xFFFE), act=1 -> p=1. cache[8]=0x7FFF, act=0x8000 -> absdiff=65535 -> p=0.
4. Backpressure. Hold out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> outputs stable, in_ready=0, cache unchanged. Release -> the queued input is accepted in the same cycle and emitted one cycle later; count shows exactly one accept.
5. Flush. Fill idx=5 with 50; pulse flush together with in_valid (idx=5, act=50) -> not accepted. Next cycle the same input -> p=0, a_cache=0.
6. Counter saturation. CNT_W=4; 1 miss then 20 hits on idx=0 -> cnt_patch=15, held. rst mid-stream -> out_valid=0, cnt_patch=0, next lookup misses.
